uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_pkg.sv | 21 ++
 rtl/uart_rx_fifo_if.sv | 31 +++
 rtl/uart_rx_fifo_mem.sv | 27 ++
 rtl/uart_rx_fifo.sv | 96 +++++++++
 tb/tb_uart_rx_fifo.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// uart_pkg: shared definitions for the UART receive FIFO.
// Holds the default byte width and helpers giving the stored entry width
// and the bit positions of the parity and stop error tags inside an entry.
// Entry layout: {stp_err, par_err, P_DATA}.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    function automatic int entry_width(input int data_width);
        return data_width + 2;
    endfunction

    function automatic int par_bit(input int data_width);
        return data_width;
    endfunction

    function automatic int stp_bit(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte stream from UART_RX into the FIFO and the
// first-word-fall-through read handshake out of it.
//   P_DATA, data_valid, par_err, stp_err : write side (from UART_RX)
//   rd_ready                             : consumer accepts head entry
//   rd_valid, rd_data, rd_par_err/stp_err: head entry presented by FIFO
// master = producer/consumer side, slave = FIFO side.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_par_err;
    logic                  rd_stp_err;

    modport master (
        output P_DATA, data_valid, par_err, stp_err, rd_ready,
        input  rd_valid, rd_data, rd_par_err, rd_stp_err
    );

    modport slave (
        input  P_DATA, data_valid, par_err, stp_err, rd_ready,
        output rd_valid, rd_data, rd_par_err, rd_stp_err
    );
endinterface

// File: rtl/uart_rx_fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array for the UART receive FIFO.
// One synchronous write port, one asynchronous read port, no reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address, wdata : write data
//   raddr : read address,  rdata : read data (combinational)
module fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO behind a UART receiver.
// Stores each byte with its parity/stop error tags, flags dropped writes
// (sticky overflow) and keeps saturating tallies of errored frames.
//   clk, rst     : clock, asynchronous active-low reset
//   bus          : write stream and read handshake (uart_rx_fifo_if.slave)
//   stat_clr     : synchronous clear of overflow and error tallies
//   count        : occupancy; full / empty : occupancy flags
//   overflow     : sticky, a write was dropped
//   par_err_cnt, stp_err_cnt : saturating error tallies
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_rx_fifo_if.slave          bus,
    input  logic                   stat_clr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic [7:0]             par_err_cnt,
    output logic [7:0]             stp_err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = entry_width(DATA_WIDTH);
    localparam int PB = par_bit(DATA_WIDTH);
    localparam int SB = stp_bit(DATA_WIDTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;
    logic          do_rd;
    logic          do_wr;
    logic          drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A read frees a slot in the same cycle, so a full FIFO can still accept.
    assign do_rd = !empty && bus.rd_ready;
    assign do_wr = bus.data_valid && (!full || do_rd);
    assign drop  = bus.data_valid && full && !do_rd;

    assign wr_entry = {bus.stp_err, bus.par_err, bus.P_DATA};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow    <= 1'b0;
            par_err_cnt <= 8'd0;
            stp_err_cnt <= 8'd0;
        end else if (stat_clr) begin
            overflow    <= 1'b0;
            par_err_cnt <= 8'd0;
            stp_err_cnt <= 8'd0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (do_wr && bus.par_err && (par_err_cnt != 8'hFF))
                par_err_cnt <= par_err_cnt + 8'd1;
            if (do_wr && bus.stp_err && (stp_err_cnt != 8'hFF))
                stp_err_cnt <= stp_err_cnt + 8'd1;
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );

    assign bus.rd_valid   = !empty;
    assign bus.rd_data    = rd_entry[DATA_WIDTH-1:0];
    assign bus.rd_par_err = rd_entry[PB];
    assign bus.rd_stp_err = rd_entry[SB];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (DEPTH=8).
module tb_uart_rx_fifo;
    logic       clk;
    logic       rst;
    logic       stat_clr;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [7:0] par_err_cnt;
    logic [7:0] stp_err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_fifo_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_fifo #(
        .DEPTH      (8),
        .DATA_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .stat_clr    (stat_clr),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .par_err_cnt (par_err_cnt),
        .stp_err_cnt (stp_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic pe, input logic se);
        bus.P_DATA     = d;
        bus.par_err    = pe;
        bus.stp_err    = se;
        bus.data_valid = 1'b1;
        step();
        bus.data_valid = 1'b0;
        bus.par_err    = 1'b0;
        bus.stp_err    = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [7:0] d, input logic pe, input logic se);
        check_val({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        check_val({tag, "_data"}, 32'(bus.rd_data), 32'(d));
        check_val({tag, "_pe"}, 32'(bus.rd_par_err), 32'(pe));
        check_val({tag, "_se"}, 32'(bus.rd_stp_err), 32'(se));
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        stat_clr       = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.data_valid = 1'b0;
        bus.par_err    = 1'b0;
        bus.stp_err    = 1'b0;
        bus.rd_ready   = 1'b0;
        #3;
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_valid", 32'(bus.rd_valid), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);
        #14 rst = 1'b1;
        step();

        // Clean single byte; no bypass before the write edge.
        bus.P_DATA     = 8'hA5;
        bus.data_valid = 1'b1;
        #1;
        check_val("nobypass_valid", 32'(bus.rd_valid), 32'd0);
        step();
        bus.data_valid = 1'b0;
        check_val("a5_count", 32'(count), 32'd1);
        rd_expect("a5", 8'hA5, 1'b0, 1'b0);
        check_val("a5_empty", 32'(empty), 32'd1);

        // Read while empty has no effect.
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        check_val("rd_empty_count", 32'(count), 32'd0);
        check_val("rd_empty_flag", 32'(empty), 32'd1);

        // Fill to full, one dropped write.
        for (int i = 0; i < 9; i++) begin
            wr(8'(i), 1'b0, 1'b0);
            if (i == 6) check_val("fill7_full", 32'(full), 32'd0);
            if (i == 7) check_val("fill8_full", 32'(full), 32'd1);
        end
        check_val("drop_count", 32'(count), 32'd8);
        check_val("drop_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) rd_expect($sformatf("fill_rd%0d", i), 8'(i), 1'b0, 1'b0);
        check_val("fill_empty", 32'(empty), 32'd1);

        // Full with simultaneous read and write.
        for (int i = 0; i < 8; i++) wr(8'(8'h10 + i), 1'b0, 1'b0);
        bus.P_DATA     = 8'h5A;
        bus.data_valid = 1'b1;
        bus.rd_ready   = 1'b1;
        step();
        bus.data_valid = 1'b0;
        bus.rd_ready   = 1'b0;
        check_val("rw_count", 32'(count), 32'd8);
        check_val("rw_full", 32'(full), 32'd1);
        for (int i = 1; i < 8; i++) rd_expect($sformatf("rw_rd%0d", i), 8'(8'h10 + i), 1'b0, 1'b0);
        rd_expect("rw_last", 8'h5A, 1'b0, 1'b0);
        check_val("rw_empty", 32'(empty), 32'd1);

        // stat_clr beats a same-cycle overflow; dropped write does not count.
        wr(8'h20, 1'b1, 1'b0);
        wr(8'h21, 1'b0, 1'b1);
        for (int i = 2; i < 8; i++) wr(8'(8'h20 + i), 1'b0, 1'b0);
        check_val("pre_clr_pcnt", 32'(par_err_cnt), 32'd1);
        check_val("pre_clr_scnt", 32'(stp_err_cnt), 32'd1);
        check_val("pre_clr_ovf", 32'(overflow), 32'd1);
        stat_clr = 1'b1;
        wr(8'hEE, 1'b1, 1'b1);
        stat_clr = 1'b0;
        check_val("clr_ovf", 32'(overflow), 32'd0);
        check_val("clr_pcnt", 32'(par_err_cnt), 32'd0);
        check_val("clr_scnt", 32'(stp_err_cnt), 32'd0);
        check_val("clr_count", 32'(count), 32'd8);
        rd_expect("clr_rd0", 8'h20, 1'b1, 1'b0);
        rd_expect("clr_rd1", 8'h21, 1'b0, 1'b1);
        for (int i = 2; i < 8; i++) rd_expect($sformatf("clr_rd%0d", i), 8'(8'h20 + i), 1'b0, 1'b0);

        // Error tags and tallies, then saturation.
        wr(8'h11, 1'b1, 1'b0);
        wr(8'h22, 1'b0, 1'b1);
        check_val("tag_pcnt", 32'(par_err_cnt), 32'd1);
        check_val("tag_scnt", 32'(stp_err_cnt), 32'd1);
        rd_expect("tag11", 8'h11, 1'b1, 1'b0);
        rd_expect("tag22", 8'h22, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            wr(8'(i), 1'b1, 1'b0);
            bus.rd_ready = 1'b1;
            step();
            bus.rd_ready = 1'b0;
        end
        check_val("sat_pcnt", 32'(par_err_cnt), 32'd255);
        check_val("sat_scnt", 32'(stp_err_cnt), 32'd1);
        check_val("sat_count", 32'(count), 32'd0);

        // Reset mid-stream.
        for (int i = 0; i < 5; i++) wr(8'(8'h40 + i), 1'b0, 1'b0);
        check_val("mid_count5", 32'(count), 32'd5);
        #1 rst = 1'b0;
        #1;
        check_val("mid_rst_count", 32'(count), 32'd0);
        check_val("mid_rst_empty", 32'(empty), 32'd1);
        check_val("mid_rst_pcnt", 32'(par_err_cnt), 32'd0);
        #2 rst = 1'b1;
        step();
        wr(8'h3C, 1'b0, 1'b0);
        check_val("post_rst_count", 32'(count), 32'd1);
        rd_expect("post_rst", 8'h3C, 1'b0, 1'b0);
        check_val("post_rst_empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
